// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - four-digit multiplexed seven-segment driver with frame-synchronous value swap
module seg7_scan_driver #(
  parameter int SLOT_CYCLES  = 12500,
  parameter int BLANK_CYCLES = 250
) (
  input  logic        clk_50MHz,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [15:0] value_i,
  input  logic [3:0]  dp_i,
  input  logic        lzb_en_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic [1:0]  digit_o,
  output logic        frame_o,
  output logic        ack_o
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] LAST_CNT  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt;
  logic [15:0]   shadow;
  logic [3:0]    shadow_dp;
  logic [15:0]   pend_value;
  logic [3:0]    pend_dp;
  logic          pend;

  logic          wrap;
  logic          boundary;
  logic          lz_blank;
  logic          blank;
  logic [3:0]    nibble;
  logic [6:0]    glyph;

  function automatic logic [6:0] hex_glyph(input logic [3:0] h);
    case (h)
      4'h0: hex_glyph = 7'b1000000;
      4'h1: hex_glyph = 7'b1111001;
      4'h2: hex_glyph = 7'b0100100;
      4'h3: hex_glyph = 7'b0110000;
      4'h4: hex_glyph = 7'b0011001;
      4'h5: hex_glyph = 7'b0010010;
      4'h6: hex_glyph = 7'b0000010;
      4'h7: hex_glyph = 7'b1111000;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0010000;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b0000011;
      4'hC: hex_glyph = 7'b1000110;
      4'hD: hex_glyph = 7'b0100001;
      4'hE: hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    wrap     = (cnt == LAST_CNT);
    boundary = wrap && (digit_o == 2'd3);
    nibble   = shadow[{digit_o, 2'b00} +: 4];
    glyph    = hex_glyph(nibble);
    // A digit is a leading zero when it and every nibble above it are zero
    case (digit_o)
      2'd3:    lz_blank = lzb_en_i && (shadow[15:12] == 4'h0);
      2'd2:    lz_blank = lzb_en_i && (shadow[15:8] == 8'h00);
      2'd1:    lz_blank = lzb_en_i && (shadow[15:4] == 12'h000);
      default: lz_blank = 1'b0;
    endcase
    blank = (cnt < BLANK_CNT) || lz_blank;
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      digit_o <= 2'd0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) digit_o <= digit_o + 2'd1;
    end
  end

  // Output stage is computed from this cycle's counter, so it trails by one clock
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      an_o  <= 4'b1111;
      seg_o <= 7'b1111111;
      dp_o  <= 1'b1;
    end else if (blank) begin
      an_o  <= 4'b1111;
      seg_o <= 7'b1111111;
      dp_o  <= 1'b1;
    end else begin
      an_o  <= ~(4'b0001 << digit_o);
      seg_o <= glyph;
      dp_o  <= ~shadow_dp[digit_o];
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= 16'h0000;
      shadow_dp  <= 4'b0000;
      pend_value <= 16'h0000;
      pend_dp    <= 4'b0000;
      pend       <= 1'b0;
      frame_o    <= 1'b0;
      ack_o      <= 1'b0;
    end else begin
      frame_o <= boundary;
      ack_o   <= boundary && (pend || load_i);
      if (load_i) begin
        pend_value <= value_i;
        pend_dp    <= dp_i;
        pend       <= 1'b1;
      end
      // A load landing on the boundary cycle bypasses the pending register
      if (boundary && (pend || load_i)) begin
        shadow    <= load_i ? value_i : pend_value;
        shadow_dp <= load_i ? dp_i : pend_dp;
        pend      <= 1'b0;
      end
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Four-digit, time-multiplexed driver for the Nexys2 common-anode seven-segment display.
- Owns its own digit scan counter and per-digit blanking interval.
- Accepts 16-bit hex values from upstream through a load strobe.
- Swaps displayed data only on frame boundaries, so a digit never shows a mix of old and new values.

Parameters:
- SLOT_CYCLES, 12500, clock cycles per digit slot (50 MHz gives a 4 kHz slot and a 1 kHz frame); must be >= 2.
- BLANK_CYCLES, 250, cycles at the start of each slot with all anodes off (anti-ghosting); must be < SLOT_CYCLES.

Ports:
- clk_50MHz  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_i  in  1  single-cycle strobe; captures value_i and dp_i.
- value_i  in  16  four hex nibbles; [3:0] is digit 0 (rightmost, AN0).
- dp_i  in  4  decimal-point enables, one per digit, active-high.
- lzb_en_i  in  1  leading-zero blanking enable (level).
- an_o  out  4  anode enables, active-low.
- seg_o  out  7  cathodes a..g, active-low; seg_o[0]=a, seg_o[6]=g.
- dp_o  out  1  decimal-point cathode, active-low.
- digit_o  out  2  index of the current slot.
- frame_o  out  1  one-cycle pulse at each frame boundary.
- ack_o  out  1  one-cycle pulse when a pending value is committed to the display.

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-frame):
  - an_o=4'b1111, seg_o=7'b1111111, dp_o=1, digit_o=0, frame_o=0, ack_o=0.
  - Slot counter=0, shadow value=16'h0000, shadow dp=4'b0000.
  - Pending flag cleared; any pending value is discarded.
- Slot counter:
  - Runs 0..SLOT_CYCLES-1, then wraps to 0.
  - digit_o increments at wrap: 0→1→2→3→0.
- Frame boundary: the cycle with counter=SLOT_CYCLES-1 and digit_o=3.
- Within each slot:
  - Counter < BLANK_CYCLES: an_o=4'b1111, seg_o=7'b1111111, dp_o=1.
  - Otherwise: an_o is all ones except bit[digit_o]=0; seg_o is the glyph of the shadow nibble; dp_o = ~shadow_dp[digit_o].
  - Per slot, the anode is low for exactly SLOT_CYCLES-BLANK_CYCLES contiguous cycles, after BLANK_CYCLES cycles high.
- Outputs are registered.
  - an_o, seg_o and dp_o lag the counter by one fixed cycle.
  - Only one anode is ever low in any cycle, including across slot wrap.
- Hex glyphs: standard, with lowercase b and d. Required values include:
  - 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110.
- Leading-zero blanking (lzb_en_i=1):
  - Digit k (k=3,2,1) is blanked when shadow nibble k and all higher nibbles are zero.
  - Digit 0 is never blanked.
  - A blanked digit keeps its anode high for the whole slot, so its dp is not shown.
  - lzb_en_i is sampled every cycle, not latched.
- Load handshake:
  - load_i=1 copies value_i/dp_i into the pending register and sets the pending flag.
  - A load while pending overwrites the pending data; no ack is produced for the overwritten value.
  - At a frame boundary with pending set (including a load on that same cycle, whose data is used): shadow ← pending, pending cleared, and ack_o=1 on the following cycle.
  - Loads never stall and the block has no busy output; at most one ack per frame.
- frame_o=1 on the cycle after each frame boundary, coincident with any ack_o.

Test Plan (SLOT_CYCLES=8, BLANK_CYCLES=2):
- Reset release, no load → digit_o cycles 0,1,2,3 every 8 cycles.
  - an_o low 6 of 8 cycles per slot, one bit at a time: 1110, 1101, 1011, 0111.
  - seg_o=1000000 while each anode is low; frame_o pulses every 32 cycles.
- Load 16'h8F1A, dp_i=4'b0100, mid-frame → no change until the boundary; ack_o and frame_o pulse together on the next cycle.
  - Next frame: digit0 seg=0001000 (A), digit1=1111001 (1), digit2=0001110 (F) with dp_o=0, digit3=0000000 (8).
- Two loads in one frame (16'h1111 then 16'h2222) → a single ack_o; 2222 is displayed; 1111 never appears.
- Load asserted exactly on the frame-boundary cycle → that value is committed at that boundary; ack_o on the next cycle.
- lzb_en_i=1 with value 16'h0050 → an_o never drives AN3 or AN2 low; AN1 shows 5 (0010010); AN0 shows 0.
  - Value 16'h0000 → only AN0 is active.
- rst_n low mid-slot with a load pending → outputs go to reset values within the same cycle (no clock edge).
  - After release: display shows 0000, no ack_o occurs, and the scan restarts at digit 0.
